// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, operator codes and state encoding for the calculator sequencer
package calc_pkg;

  localparam int CALC_WIDTH   = 16;
  localparam int CALC_MAX_MAG = 32767;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_NEG  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;

  localparam logic [15:0] ERR_DISPLAY = 16'h8000;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_EXEC,
    ST_WAIT_ALU,
    ST_RESULT,
    ST_ERROR
  } state_t;

  function automatic logic is_binary_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/decimal_entry.sv
// rtl/decimal_entry.sv - sign/magnitude decimal operand register with digit append, reject, negate, clear and load
module decimal_entry
  import calc_pkg::*;
#(
  parameter int WIDTH   = CALC_WIDTH,
  parameter int MAX_MAG = CALC_MAX_MAG
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             digit_en,
  input  logic [3:0]       digit,
  input  logic             neg_en,
  output logic [WIDTH-1:0] value,
  output logic             entered
);

  localparam int EW = WIDTH + 4;

  logic [WIDTH-1:0] mag;
  logic             sign;
  logic [EW-1:0]    appended;
  logic             fits;

  assign appended = EW'(mag) * EW'(10) + EW'(digit);
  assign fits     = (appended <= EW'(MAX_MAG));

  always_ff @(posedge clk) begin
    if (RST || clear) begin
      mag     <= '0;
      sign    <= 1'b0;
      entered <= 1'b0;
    end else if (load) begin
      // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
      sign    <= load_value[WIDTH-1];
      mag     <= load_value[WIDTH-1] ? -load_value : load_value;
      entered <= 1'b0;
    end else begin
      if (digit_en) begin
        entered <= 1'b1;
        if (fits) begin
          mag <= appended[WIDTH-1:0];
        end
      end
      if (neg_en) begin
        sign <= ~sign;
      end
    end
  end

  assign value = sign ? -mag : mag;

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator key/ALU sequencer; CALC_OVERFLOW_CHECK_EN adds the overflow ERROR state
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH   = CALC_WIDTH,
  parameter int MAX_MAG = CALC_MAX_MAG
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             read_input,
  input  logic [3:0]       keypad_input,
  input  logic [2:0]       operator_input,
  input  logic             equal_input,
  output logic             key_read,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic [WIDTH-1:0] display_value,
  output logic             error,
  output logic             busy
);

  state_t           state, state_next;
  logic             armed, consume;
  logic             key_eq, key_neg, key_bin, key_digit;
  logic             op_we;
  logic             a_digit, a_neg, a_load;
  logic [WIDTH-1:0] a_load_value;
  logic             b_digit, b_neg, b_clear;
  logic [WIDTH-1:0] a_value, b_value;
  logic             b_entered, unused_a_entered;

  assign busy      = (state == ST_EXEC) || (state == ST_WAIT_ALU);
  assign consume   = read_input && armed && !busy;
  assign key_eq    = equal_input;
  assign key_neg   = !equal_input && (operator_input == OP_NEG);
  assign key_bin   = !equal_input && is_binary_op(operator_input);
  assign key_digit = !equal_input && (operator_input == OP_NONE) && (keypad_input <= 4'd9);

  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= ST_ENTER_A;
      armed    <= 1'b1;
      key_read <= 1'b0;
      alu_op   <= OP_ADD;
    end else begin
      state    <= state_next;
      key_read <= consume;
      // Re-arm only after the front end drops its request, so a held key counts once.
      if (consume) armed <= 1'b0;
      else if (!read_input) armed <= 1'b1;
      if (op_we) alu_op <= operator_input;
    end
  end

  always_comb begin
    state_next   = state;
    op_we        = 1'b0;
    a_digit      = 1'b0;
    a_neg        = 1'b0;
    a_load       = 1'b0;
    a_load_value = '0;
    b_digit      = 1'b0;
    b_neg        = 1'b0;
    b_clear      = 1'b0;
    case (state)
      ST_ENTER_A: if (consume) begin
        if (key_bin) begin
          op_we = 1'b1; b_clear = 1'b1; state_next = ST_ENTER_B;
        end else if (key_neg) a_neg = 1'b1;
        else if (key_digit) a_digit = 1'b1;
      end
      ST_ENTER_B: if (consume) begin
        if (key_eq) state_next = ST_EXEC;
        else if (key_bin) op_we = 1'b1;
        else if (key_neg) b_neg = 1'b1;
        else if (key_digit) b_digit = 1'b1;
      end
      ST_EXEC: state_next = ST_WAIT_ALU;
      ST_WAIT_ALU: if (alu_done) begin
`ifdef CALC_OVERFLOW_CHECK_EN
        if (alu_overflow) state_next = ST_ERROR;
        else begin
          a_load = 1'b1; a_load_value = alu_result; state_next = ST_RESULT;
        end
`else
        a_load = 1'b1; a_load_value = alu_result; state_next = ST_RESULT;
`endif
      end
      // The result already lives in A, so chaining and repeat-equals reuse it directly.
      ST_RESULT: if (consume) begin
        if (key_eq) state_next = ST_EXEC;
        else if (key_bin) begin
          op_we = 1'b1; b_clear = 1'b1; state_next = ST_ENTER_B;
        end else if (key_neg) a_neg = 1'b1;
        else if (key_digit) begin
          a_load = 1'b1; a_load_value = WIDTH'(keypad_input); state_next = ST_ENTER_A;
        end
      end
`ifdef CALC_OVERFLOW_CHECK_EN
      ST_ERROR: if (consume && key_digit) begin
        a_load = 1'b1; a_load_value = WIDTH'(keypad_input); state_next = ST_ENTER_A;
      end
`endif
      default: state_next = ST_ENTER_A;
    endcase
  end

  always_comb begin
    display_value = a_value;
    case (state)
      ST_ENTER_B, ST_EXEC, ST_WAIT_ALU: display_value = b_entered ? b_value : a_value;
      ST_ERROR: display_value = WIDTH'(ERR_DISPLAY);
      default: display_value = a_value;
    endcase
  end

`ifdef CALC_OVERFLOW_CHECK_EN
  assign error = (state == ST_ERROR);
`else
  logic unused_overflow;
  assign unused_overflow = alu_overflow;
  assign error = 1'b0;
`endif

  assign alu_a     = a_value;
  assign alu_b     = b_value;
  assign alu_start = (state == ST_EXEC);

  decimal_entry #(.WIDTH(WIDTH), .MAX_MAG(MAX_MAG)) u_entry_a (
    .clk(clk), .RST(RST), .clear(1'b0), .load(a_load), .load_value(a_load_value),
    .digit_en(a_digit), .digit(keypad_input), .neg_en(a_neg),
    .value(a_value), .entered(unused_a_entered)
  );

  decimal_entry #(.WIDTH(WIDTH), .MAX_MAG(MAX_MAG)) u_entry_b (
    .clk(clk), .RST(RST), .clear(b_clear), .load(1'b0), .load_value('0),
    .digit_en(b_digit), .digit(keypad_input), .neg_en(b_neg),
    .value(b_value), .entered(b_entered)
  );

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        read_input = 1'b0;
  logic [3:0]  keypad_input = 4'd0;
  logic [2:0]  operator_input = 3'd0;
  logic        equal_input = 1'b0;
  logic        key_read;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'd0;
  logic        alu_overflow = 1'b0;
  logic [15:0] display_value;
  logic        error;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int kr_count = 0;
  int start_count = 0;
  int alu_cnt = 0;
  logic alu_pending = 1'b0;
  int alu_delay_cfg = 3;
  logic [15:0] alu_res_cfg = 16'd0;
  logic alu_ovf_cfg = 1'b0;
  logic [15:0] cap_a = 16'd0, cap_b = 16'd0;
  logic [2:0]  cap_op = 3'd0;

  calc_sequencer dut (
    .clk(clk), .RST(RST), .read_input(read_input), .keypad_input(keypad_input),
    .operator_input(operator_input), .equal_input(equal_input), .key_read(key_read),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .display_value(display_value), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_read === 1'b1) kr_count++;
  end

  // ALU stand-in: captures operands on alu_start, answers alu_delay_cfg cycles later.
  always @(negedge clk) begin
    alu_done = 1'b0;
    if (alu_start === 1'b1) begin
      start_count++;
      cap_a = alu_a; cap_b = alu_b; cap_op = alu_op;
      alu_cnt = alu_delay_cfg;
      alu_pending = 1'b1;
    end else if (alu_pending) begin
      alu_cnt--;
      if (alu_cnt <= 0) begin
        alu_done = 1'b1; alu_result = alu_res_cfg; alu_overflow = alu_ovf_cfg;
        alu_pending = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1; read_input = 1'b0; equal_input = 1'b0; operator_input = 3'd0; keypad_input = 4'd0;
    alu_ovf_cfg = 1'b0; alu_delay_cfg = 3;
    repeat (2) @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic eq, input logic [2:0] op, input logic [3:0] dig);
    int n;
    @(negedge clk);
    equal_input = eq; operator_input = op; keypad_input = dig; read_input = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (key_read !== 1'b1 && n < 100);
    if (key_read !== 1'b1) begin
      checks++; errors++;
      $display("FAIL key_ack timeout key_read=%b expected 1", key_read);
    end
    @(negedge clk);
    read_input = 1'b0; equal_input = 1'b0; operator_input = 3'd0; keypad_input = 4'd0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL %s busy timeout busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (key_read !== 1'b0) begin errors++; $display("FAIL rst_key_read got %b exp 0", key_read); end
    checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL rst_alu_start got %b exp 0", alu_start); end
    checks++; if (alu_a !== 16'd0) begin errors++; $display("FAIL rst_alu_a got %h exp 0000", alu_a); end
    checks++; if (alu_b !== 16'd0) begin errors++; $display("FAIL rst_alu_b got %h exp 0000", alu_b); end
    checks++; if (alu_op !== 3'b010) begin errors++; $display("FAIL rst_alu_op got %b exp 010", alu_op); end
    checks++; if (display_value !== 16'd0) begin errors++; $display("FAIL rst_display got %h exp 0000", display_value); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b exp 0", error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
  endtask

  task automatic test_add();
    int s0;
    do_reset();
    s0 = start_count;
    press(0, 3'd0, 4'd1); press(0, 3'd0, 4'd2); press(0, 3'b010, 4'd0);
    checks++; if (display_value !== 16'd12) begin errors++; $display("FAIL add_display_a got %0d exp 12", display_value); end
    press(0, 3'd0, 4'd7);
    checks++; if (display_value !== 16'd7) begin errors++; $display("FAIL add_display_b got %0d exp 7", display_value); end
    alu_res_cfg = 16'd19; alu_delay_cfg = 3;
    press(1, 3'd0, 4'd0);
    wait_idle("add");
    checks++; if (cap_a !== 16'd12) begin errors++; $display("FAIL add_alu_a got %0d exp 12", cap_a); end
    checks++; if (cap_b !== 16'd7) begin errors++; $display("FAIL add_alu_b got %0d exp 7", cap_b); end
    checks++; if (cap_op !== 3'b010) begin errors++; $display("FAIL add_alu_op got %b exp 010", cap_op); end
    checks++; if (start_count - s0 !== 1) begin errors++; $display("FAIL add_start_count got %0d exp 1", start_count - s0); end
    checks++; if (display_value !== 16'd19) begin errors++; $display("FAIL add_result got %0d exp 19", display_value); end
  endtask

  task automatic test_mul_neg_repeat();
    int s0;
    do_reset();
    s0 = start_count;
    press(0, 3'd0, 4'd3); press(0, 3'b100, 4'd0); press(0, 3'd0, 4'd4); press(0, 3'b001, 4'd0);
    checks++; if (display_value !== 16'hFFFC) begin errors++; $display("FAIL mul_display_b got %h exp fffc", display_value); end
    alu_res_cfg = 16'hFFF4;
    press(1, 3'd0, 4'd0);
    wait_idle("mul");
    checks++; if (cap_b !== 16'hFFFC) begin errors++; $display("FAIL mul_alu_b got %h exp fffc", cap_b); end
    checks++; if (cap_op !== 3'b100) begin errors++; $display("FAIL mul_alu_op got %b exp 100", cap_op); end
    checks++; if (display_value !== 16'hFFF4) begin errors++; $display("FAIL mul_result got %h exp fff4", display_value); end
    alu_res_cfg = 16'h0030;
    press(1, 3'd0, 4'd0);
    wait_idle("repeat");
    checks++; if (cap_a !== 16'hFFF4) begin errors++; $display("FAIL repeat_alu_a got %h exp fff4", cap_a); end
    checks++; if (cap_b !== 16'hFFFC) begin errors++; $display("FAIL repeat_alu_b got %h exp fffc", cap_b); end
    checks++; if (start_count - s0 !== 2) begin errors++; $display("FAIL repeat_start_count got %0d exp 2", start_count - s0); end
    checks++; if (display_value !== 16'h0030) begin errors++; $display("FAIL repeat_result got %h exp 0030", display_value); end
  endtask

  task automatic test_saturation();
    int k0;
    logic [3:0] digs [6];
    digs = '{4'd3, 4'd2, 4'd7, 4'd6, 4'd7, 4'd9};
    do_reset();
    k0 = kr_count;
    for (int i = 0; i < 6; i++) press(0, 3'd0, digs[i]);
    checks++; if (display_value !== 16'd32767) begin errors++; $display("FAIL sat_display got %0d exp 32767", display_value); end
    checks++; if (kr_count - k0 !== 6) begin errors++; $display("FAIL sat_key_reads got %0d exp 6", kr_count - k0); end
    press(0, 3'b001, 4'd0);
    checks++; if (display_value !== 16'h8001) begin errors++; $display("FAIL sat_neg got %h exp 8001", display_value); end
  endtask

  task automatic test_held_key();
    int k0;
    do_reset();
    k0 = kr_count;
    @(negedge clk);
    keypad_input = 4'd4; read_input = 1'b1;
    repeat (20) @(negedge clk);
    read_input = 1'b0;
    @(negedge clk); #1;
    checks++; if (kr_count - k0 !== 1) begin errors++; $display("FAIL held_key_reads got %0d exp 1", kr_count - k0); end
    checks++; if (display_value !== 16'd4) begin errors++; $display("FAIL held_display got %0d exp 4", display_value); end
    keypad_input = 4'd5; read_input = 1'b1;
    repeat (5) @(negedge clk);
    read_input = 1'b0;
    @(negedge clk); #1;
    checks++; if (kr_count - k0 !== 2) begin errors++; $display("FAIL repress_key_reads got %0d exp 2", kr_count - k0); end
    checks++; if (display_value !== 16'd45) begin errors++; $display("FAIL repress_display got %0d exp 45", display_value); end
  endtask

  task automatic test_overflow();
    logic [3:0] a_digs [5];
    logic [3:0] b_digs [4];
    a_digs = '{4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
    b_digs = '{4'd5, 4'd0, 4'd0, 4'd0};
    do_reset();
    for (int i = 0; i < 5; i++) press(0, 3'd0, a_digs[i]);
    press(0, 3'b010, 4'd0);
    for (int i = 0; i < 4; i++) press(0, 3'd0, b_digs[i]);
    alu_res_cfg = 16'h88B8; alu_ovf_cfg = 1'b1;
    press(1, 3'd0, 4'd0);
    wait_idle("ovf");
    checks++; if (cap_a !== 16'd30000) begin errors++; $display("FAIL ovf_alu_a got %0d exp 30000", cap_a); end
`ifdef CALC_OVERFLOW_CHECK_EN
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error got %b exp 1", error); end
    checks++; if (display_value !== 16'h8000) begin errors++; $display("FAIL ovf_display got %h exp 8000", display_value); end
`else
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf_error got %b exp 0", error); end
    checks++; if (display_value !== 16'h88B8) begin errors++; $display("FAIL ovf_display got %h exp 88b8", display_value); end
`endif
    alu_ovf_cfg = 1'b0;
    press(0, 3'd0, 4'd5);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf_clear_error got %b exp 0", error); end
    checks++; if (display_value !== 16'd5) begin errors++; $display("FAIL ovf_clear_display got %0d exp 5", display_value); end
  endtask

  task automatic test_reset_in_wait();
    int s0;
    do_reset();
    press(0, 3'd0, 4'd1); press(0, 3'b011, 4'd0); press(0, 3'd0, 4'd2);
    alu_res_cfg = 16'hFFFF; alu_delay_cfg = 8;
    press(1, 3'd0, 4'd0);
    s0 = start_count;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got %b exp 1", busy); end
    @(negedge clk); RST = 1'b1;
    @(negedge clk); RST = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy got %b exp 0", busy); end
    checks++; if (display_value !== 16'd0) begin errors++; $display("FAIL rstw_display got %h exp 0000", display_value); end
    checks++; if (alu_op !== 3'b010) begin errors++; $display("FAIL rstw_alu_op got %b exp 010", alu_op); end
    checks++; if (alu_a !== 16'd0 || alu_b !== 16'd0) begin errors++; $display("FAIL rstw_operands got %h/%h exp 0000/0000", alu_a, alu_b); end
    checks++; if (key_read !== 1'b0 || alu_start !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL rstw_strobes got kr=%b st=%b err=%b exp 0/0/0", key_read, alu_start, error);
    end
    checks++; if (start_count !== s0) begin errors++; $display("FAIL rstw_no_start got %0d exp %0d", start_count, s0); end
    press(0, 3'd0, 4'd7);
    checks++; if (display_value !== 16'd7) begin errors++; $display("FAIL rstw_enter_a got %0d exp 7", display_value); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_neg_repeat();
    test_saturation();
    test_held_key();
    test_overflow();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Top-level sequencer for the 16-bit signed calculator. It consumes key events from the keypad front end over the `read_input`/`key_read` handshake and builds two signed decimal operands plus an operator. On equals it launches one ALU operation, then latches the result for display. It is the only block that drives the shared ALU and the display register, and it supports chained operations (result becomes operand A).

## Interface
- `WIDTH`, 16, operand/result width (two's complement)
- `MAX_MAG`, 32767, largest magnitude accepted during digit entry
- `clk` in 1: system clock
- `RST` in 1: synchronous, active-high reset; one clock, no other clock domains
- `read_input` in 1: key event pending from keypad front end
- `keypad_input` in 4: decimal digit 0–9
- `operator_input` in 3: 001 neg, 010 add, 011 sub, 100 mul, 000 none
- `equal_input` in 1: equals key
- `key_read` out 1: one-cycle acknowledge of a consumed key
- `alu_a`, `alu_b` out WIDTH: operands, stable from `alu_start` until `alu_done`
- `alu_op` out 3: operator code (add/sub/mul only)
- `alu_start` out 1: one-cycle launch pulse
- `alu_done` in 1: one-cycle completion pulse
- `alu_result` in WIDTH: valid when `alu_done`
- `alu_overflow` in 1: valid when `alu_done`
- `display_value` out WIDTH: value shown (entry in progress or result)
- `error` out 1: overflow error latched
- `busy` out 1: high in EXEC/WAIT_ALU

## Operation
- Key classification priority: `equal_input` > `operator_input != 0` > digit.
- Consume rule: a key is consumed when `read_input` is high, the internal `armed` flag is set, and the state is not EXEC/WAIT_ALU. Consuming clears `armed`. `armed` is set again only after `read_input` has been sampled low. A held key is therefore consumed exactly once.
- States:
  - ENTER_A: digits accumulate into A. neg toggles the sign of A. add/sub/mul stores `alu_op` and goes to ENTER_B with B=0. equals is ignored.
  - ENTER_B: digits accumulate into B. neg toggles the sign of B. A further operator replaces `alu_op` (no evaluation). equals goes to EXEC.
  - EXEC: drive operands, pulse `alu_start`, then go to WAIT_ALU.
  - WAIT_ALU: on `alu_done` go to RESULT, or to ERROR if overflow (see Configuration).
  - RESULT: operator loads A = result, stores the op and goes to ENTER_B. A digit clears, sets A = digit and goes to ENTER_A. neg negates the result in place. equals repeats the last op with the same B (goes to EXEC).
  - ERROR: `display_value`=16'h8000, `error`=1. Any digit clears `error`, sets A = digit and goes to ENTER_A. Other keys are consumed and ignored.
- Digit entry:
  - Compute magnitude·10 + digit at 20 bits unsigned.
  - If the sum exceeds `MAX_MAG`, the digit is consumed but discarded (value unchanged).
  - The sign is applied separately, so neg on 0 keeps 0.
- Arithmetic: mul keeps the low WIDTH bits. The sequencer never computes; the ALU does.
- `display_value`: current A in ENTER_A, current B in ENTER_B (A if no digit yet entered), result in RESULT.

## Timing
- Reset values: `key_read`=0, `alu_start`=0, `alu_a`=`alu_b`=0, `alu_op`=3'b010, `display_value`=0, `error`=0, `busy`=0. State ENTER_A, `armed`=1.
- `key_read` is registered: it goes high the cycle after the consume condition is sampled, for exactly one cycle. Operand/state updates occur on the same edge.
- Key refused while busy: `key_read` stays low and the front end holds its request.
- equals consumed at edge N: EXEC at N+1, `alu_start` high during N+1 → N+2, WAIT_ALU from N+2.
- `alu_done` at edge M: `display_value` and state update at M+1, `busy` low from M+1.
- `alu_done` during EXEC is illegal and ignored.
- `RST` mid-operation (any state, including WAIT_ALU): next-edge return to reset values. A later `alu_done` is ignored.

## Configuration
- `CALC_OVERFLOW_CHECK_EN` defined: `alu_overflow` with `alu_done` → ERROR state, `error`=1.
- Undefined: `alu_overflow` is ignored, the wrapped `alu_result` goes to RESULT, `error` is tied 0 and the ERROR state is not synthesized.

## Structure
- Package `calc_pkg`:
  - operator codes (OP_NONE/NEG/ADD/SUB/MUL)
  - state enum
  - `WIDTH` default, `MAX_MAG`
  - error display constant 16'h8000
- Sub-module `decimal_entry`: sign/magnitude register with digit-append, saturation reject, sign toggle, clear and load. Instantiated twice (A and B).

## Test plan
- Keys 1,2,add,7,equals (`alu_done` after 3 cycles, result 19) → `alu_a`=12, `alu_b`=7, `alu_op`=010, one `alu_start`, `display_value`=19.
- Keys 3,mul,4,neg,equals, result −12 → `alu_b`=16'hFFFC, `display_value`=16'hFFF4. Equals again → second `alu_start` with `alu_a`=16'hFFF4, `alu_b`=16'hFFFC.
- Digits 3,2,7,6,7,9 → `display_value`=32767, six `key_read` pulses, sixth digit discarded.
- `read_input` held high 20 cycles for one digit → exactly one `key_read`. A second press after a low cycle → a second `key_read`.
- With macro: 30000 add 5000 equals, `alu_overflow`=1 → `error`=1, `display_value`=16'h8000. Digit 5 → `error`=0, display 5. Without macro, the same stimulus → wrapped result, `error`=0.
- `RST` pulsed in WAIT_ALU, then `alu_done` → all outputs at reset values, no state change, `busy`=0.
